// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the FIFO pointer/status controller.
package fifo_pkg;

    // Accepted operation for the current cycle, encoded as {wr_ok, rd_ok}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_WR   = 2'b10,
        OP_RD   = 2'b01,
        OP_RW   = 2'b11
    } op_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // almost_full threshold must be reachable (1..DEPTH).
    function automatic bit af_level_ok(input int aw, input int lvl);
        return (lvl >= 1) && (lvl <= depth_of(aw));
    endfunction

    // almost_empty threshold must leave full distinguishable (0..DEPTH-1).
    function automatic bit ae_level_ok(input int aw, input int lvl);
        return (lvl >= 0) && (lvl < depth_of(aw));
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping address pointer with increment enable and synchronous reset.
module fifo_ptr #(
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    output logic [A_WIDTH-1:0] addr
);

    // Advance by one on inc; natural modulo-DEPTH wrap from the register width.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (inc) begin
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl_stat.sv
// FIFO pointer/status controller: accept strobes, RAM addresses, occupancy
// count, registered threshold status and sticky error flags.
module fifo_ctrl_stat
    import fifo_pkg::*;
#(
    parameter int A_WIDTH  = 4,
    parameter int AF_LEVEL = 2**A_WIDTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic               clr_err,
    output logic               wr_ok,
    output logic               rd_ok,
    output logic [A_WIDTH-1:0] w_addr,
    output logic [A_WIDTH-1:0] r_addr,
    output logic [A_WIDTH:0]   count,
    output logic               empty,
    output logic               full,
    output logic               almost_empty,
    output logic               almost_full,
    output logic               overflow,
    output logic               underflow
);

    localparam int             DEPTH   = depth_of(A_WIDTH);
    localparam logic [A_WIDTH:0] DEPTH_C = DEPTH[A_WIDTH:0];
    localparam logic [A_WIDTH:0] AF_C    = AF_LEVEL[A_WIDTH:0];
    localparam logic [A_WIDTH:0] AE_C    = AE_LEVEL[A_WIDTH:0];

    if (!af_level_ok(A_WIDTH, AF_LEVEL)) begin : g_bad_af_level
        $error("fifo_ctrl_stat: AF_LEVEL must lie in 1..DEPTH");
    end

    if (!ae_level_ok(A_WIDTH, AE_LEVEL)) begin : g_bad_ae_level
        $error("fifo_ctrl_stat: AE_LEVEL must lie in 0..DEPTH-1");
    end

    op_t              op;
    logic [A_WIDTH:0] count_next;

    // Accept strobes: a write into a full FIFO rides on a simultaneous read;
    // nothing is accepted while reset is high.
    always_comb begin
        rd_ok = ~reset & rd & ~empty;
        wr_ok = ~reset & wr & (~full | rd);
        op    = op_t'({wr_ok, rd_ok});
    end

    // Next occupancy; accept rules keep it inside 0..DEPTH.
    always_comb begin
        count_next = count;
        case (op)
            OP_WR:   count_next = count + 1'b1;
            OP_RD:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    fifo_ptr #(.A_WIDTH(A_WIDTH)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_ok),
        .addr  (w_addr)
    );

    fifo_ptr #(.A_WIDTH(A_WIDTH)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_ok),
        .addr  (r_addr)
    );

    // Occupancy and status registered from count_next so they track count with no lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == DEPTH_C);
            almost_empty <= (count_next <= AE_C);
            almost_full  <= (count_next >= AF_C);
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr & ~wr_ok) | (overflow  & ~clr_err);
            underflow <= (rd & ~rd_ok) | (underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_stat.sv
// Bench for fifo_ctrl_stat: directed boundary scenarios then random traffic,
// compared against a queue-based occupancy model.
module tb_fifo_ctrl_stat;

    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic          clr_err = 1'b0;
    logic          wr_ok, rd_ok;
    logic [AW-1:0] w_addr, r_addr;
    logic [AW:0]   count;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;

    int tests = 0;
    int fails = 0;

    int q[$];
    int wcnt = 0;
    int rcnt = 0;
    int tag_data = 0;
    bit m_ov = 0;
    bit m_un = 0;

    always #5 clk = ~clk;

    fifo_ctrl_stat #(.A_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .clr_err      (clr_err),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .w_addr       (w_addr),
        .r_addr       (r_addr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string ctx);
        int n;
        n = q.size();
        check({ctx, ":count"},        32'(count),        32'(n));
        check({ctx, ":w_addr"},       32'(w_addr),       32'(wcnt % DEPTH));
        check({ctx, ":r_addr"},       32'(r_addr),       32'(rcnt % DEPTH));
        check({ctx, ":empty"},        32'(empty),        32'(n == 0));
        check({ctx, ":full"},         32'(full),         32'(n == DEPTH));
        check({ctx, ":almost_full"},  32'(almost_full),  32'(n >= AF));
        check({ctx, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check({ctx, ":overflow"},     32'(overflow),     32'(m_ov));
        check({ctx, ":underflow"},    32'(underflow),    32'(m_un));
    endtask

    // One cycle of traffic: check the same-cycle strobes, then the post-edge state.
    task automatic step(input string ctx, input bit w, input bit r, input bit c);
        bit ewr, erd;
        @(negedge clk);
        wr = w; rd = r; clr_err = c;
        #1;
        erd = r && (q.size() > 0);
        ewr = w && ((q.size() < DEPTH) || r);
        check({ctx, ":wr_ok"}, 32'(wr_ok), 32'(ewr));
        check({ctx, ":rd_ok"}, 32'(rd_ok), 32'(erd));
        @(posedge clk);
        #1;
        if (erd) begin
            void'(q.pop_front());
            rcnt++;
        end
        if (ewr) begin
            q.push_back(tag_data++);
            wcnt++;
        end
        m_ov = (w && !ewr) || (m_ov && !c);
        m_un = (r && !erd) || (m_un && !c);
        check_state(ctx);
    endtask

    // Reset for one edge with the given requests held; strobes must stay low.
    task automatic do_reset(input string ctx, input bit w, input bit r);
        @(negedge clk);
        reset = 1'b1; wr = w; rd = r; clr_err = 1'b0;
        #1;
        check({ctx, ":wr_ok_in_reset"}, 32'(wr_ok), 32'd0);
        check({ctx, ":rd_ok_in_reset"}, 32'(rd_ok), 32'd0);
        @(posedge clk);
        #1;
        q.delete();
        wcnt = 0; rcnt = 0; m_ov = 0; m_un = 0;
        check_state(ctx);
        @(negedge clk);
        reset = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        do_reset("init", 1'b1, 1'b0);
        step("idle", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 1'b0);
        step("wr_full", 1'b1, 1'b0, 1'b0);
        step("clr_ov", 1'b0, 1'b0, 1'b1);
        step("rw_full", 1'b1, 1'b1, 1'b0);
        step("rw_full2", 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b1, 1'b0);
        step("rw_empty", 1'b1, 1'b1, 1'b0);
        step("rd_drain", 1'b0, 1'b1, 1'b0);
        step("rd_empty_clr", 1'b0, 1'b1, 1'b1);
        step("clr_un", 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            bit w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 10);
            step("rand", w, r, c);
        end

        do_reset("mid_reset_prep", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("prep", 1'b1, 1'b0, 1'b0);
        check("prep_count3", 32'(count), 32'd3);
        do_reset("mid_reset", 1'b1, 1'b1);
        step("after_reset", 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
